// File: rtl/morse_keyer_tx_if.sv
// morse_keyer_tx_if: code word handshake and keyed line status of the Morse keyer
interface morse_keyer_tx_if #(parameter int NSYM = 12);
  logic [2*NSYM-1:0] code;
  logic valid;
  logic ready;
  logic key_out;
  logic busy;
  logic done;
  modport master (output code, valid, input ready, key_out, busy, done);
  modport slave (input code, valid, output ready, key_out, busy, done);
endinterface

// File: rtl/morse_keyer_tx.sv
// morse_keyer_tx: turns a latched code word of 2-bit dot/dash slots into a timed keyed Morse line
module morse_keyer_tx #(
  parameter int K = 50,
  parameter int NSYM = 12
) (
  input logic clk,
  input logic rst,
  morse_keyer_tx_if.slave bus
);
  localparam int W = $clog2(3*K);
  localparam int IW = $clog2(NSYM+1);
  localparam logic [W-1:0] L1 = W'(K-1);
  localparam logic [W-1:0] L3 = W'(3*K-1);
  localparam logic [W-1:0] L3M = W'(3*K-2);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, CGAP} state_t;
  state_t state;
  logic [2*NSYM-1:0] code_r;
  logic [IW-1:0] idx;
  logic [W-1:0] cnt;
  logic [1:0] slots [2**IW];
  logic [1:0] cur, nxt, first;
  // slots past NSYM read as terminators so a lookahead from the last slot ends the character
  genvar i;
  for (i = 0; i < 2**IW; i++) begin : g_slot
    if (i < NSYM) begin : g_v
      assign slots[i] = code_r[2*NSYM-1-2*i -: 2];
    end else begin : g_z
      assign slots[i] = 2'b00;
    end
  end
  assign cur = slots[idx];
  assign nxt = slots[idx + 1'b1];
  assign first = bus.code[2*NSYM-1 -: 2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      code_r <= '0;
      idx <= '0;
      cnt <= '0;
      bus.key_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.valid && bus.ready) begin
          code_r <= bus.code;
          idx <= '0;
          cnt <= '0;
          bus.busy <= 1'b1;
          bus.ready <= 1'b0;
          bus.key_out <= ^first;
          state <= (^first) ? MARK : CGAP;
        end
        MARK: if (cnt == ((cur == 2'b10) ? L3 : L1)) begin
          cnt <= '0;
          bus.key_out <= 1'b0;
          idx <= (^nxt) ? idx + 1'b1 : idx;
          state <= (^nxt) ? SPACE : CGAP;
        end else cnt <= cnt + 1'b1;
        SPACE: if (cnt == L1) begin
          cnt <= '0;
          bus.key_out <= 1'b1;
          state <= MARK;
        end else cnt <= cnt + 1'b1;
        CGAP: begin
          bus.done <= (cnt == L3M);
          if (cnt == L3) begin
            cnt <= '0;
            bus.busy <= 1'b0;
            bus.ready <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_keyer_tx.sv
// tb_morse_keyer_tx: scoreboard bench driving three keyers (K = 4, 1, 2) and checking the keyed waveform cycle by cycle
module tb_morse_keyer_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [23:0] cd [3];
  logic vld [3];
  logic [2:0] obs [3];
  logic rdy [3];
  morse_keyer_tx_if b0();
  morse_keyer_tx_if b1();
  morse_keyer_tx_if b2();
  assign b0.code = cd[0];
  assign b0.valid = vld[0];
  assign b1.code = cd[1];
  assign b1.valid = vld[1];
  assign b2.code = cd[2];
  assign b2.valid = vld[2];
  assign obs[0] = {b0.key_out, b0.busy, b0.done};
  assign obs[1] = {b1.key_out, b1.busy, b1.done};
  assign obs[2] = {b2.key_out, b2.busy, b2.done};
  assign rdy[0] = b0.ready;
  assign rdy[1] = b1.ready;
  assign rdy[2] = b2.ready;
  morse_keyer_tx #(.K(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  morse_keyer_tx #(.K(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  morse_keyer_tx #(.K(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  int checks = 0;
  int errors = 0;
  logic [2:0] sb [$];
  // expected {key_out, busy, done} per cycle after the accept edge
  task automatic model(input logic [23:0] c, input int k);
    logic [1:0] s;
    for (int i = 0; i < 12; i++) begin
      s = c[23-2*i -: 2];
      if (s == 2'b00 || s == 2'b11) break;
      if (i > 0) repeat (k) sb.push_back(3'b010);
      repeat (k * ((s == 2'b10) ? 3 : 1)) sb.push_back(3'b110);
    end
    repeat (3*k) sb.push_back(3'b010);
    sb[sb.size()-1] = 3'b011;
  endtask
  task automatic accept(input int sel, input logic [23:0] c, input string name);
    @(negedge clk);
    cd[sel] = c;
    vld[sel] = 1'b1;
    checks++;
    if (rdy[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready before accept: got %b want 1", name, rdy[sel]);
    end
    @(posedge clk);
    #1 vld[sel] = 1'b0;
    cd[sel] = 24'($urandom);
  endtask
  task automatic consume(input int sel, input string name);
    int n = 0;
    logic [2:0] e;
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      e = sb.pop_front();
      checks++;
      if (obs[sel] !== e) begin
        errors++;
        $display("FAIL %s cycle %0d key/busy/done: got %b want %b", name, n, obs[sel], e);
      end
    end
  endtask
  task automatic check_idle(input int sel, input string name);
    @(negedge clk);
    checks++;
    if (obs[sel] !== 3'b000 || rdy[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: key/busy/done=%b ready=%b want 000 ready=1", name, obs[sel], rdy[sel]);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      vld[s] = 1'b0;
      cd[s] = '0;
    end
    #12;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (obs[s] !== 3'b000 || rdy[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset inst %0d: key/busy/done=%b ready=%b want 000 ready=1", s, obs[s], rdy[s]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset_mid_dash();
    accept(0, 24'h800000, "rst_dash");
    repeat (5) @(negedge clk);
    checks++;
    if (obs[0] !== 3'b110) begin
      errors++;
      $display("FAIL rst_dash before reset: got %b want 110", obs[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs[0] !== 3'b000 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_dash async: key/busy/done=%b ready=%b want 000 ready=1", obs[0], rdy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_char(input int sel, input int k, input logic [23:0] c, input string name);
    model(c, k);
    accept(sel, c, name);
    consume(sel, name);
    check_idle(sel, name);
  endtask
  task automatic test_back_to_back();
    int n = 0;
    logic [2:0] e;
    model(24'h400000, 2);
    sb.push_back(3'b000);
    model(24'h800000, 2);
    @(negedge clk);
    cd[2] = 24'h400000;
    vld[2] = 1'b1;
    @(posedge clk);
    #1 cd[2] = 24'h800000;
    while (sb.size() > 0) begin
      @(negedge clk);
      n++;
      e = sb.pop_front();
      checks++;
      if (obs[2] !== e) begin
        errors++;
        $display("FAIL b2b cycle %0d key/busy/done: got %b want %b", n, obs[2], e);
      end
      if (n >= 10 && n <= 18) begin
        vld[2] = n[0];
        cd[2] = 24'($urandom);
      end else if (n >= 19) vld[2] = 1'b0;
    end
    check_idle(2, "b2b");
  endtask
  initial begin
    test_reset();
    test_reset_mid_dash();
    test_char(0, 4, 24'h600000, "char_A");
    test_char(0, 4, 24'h000000, "empty");
    test_char(1, 1, 24'h555555, "full_k1");
    test_back_to_back();
    test_char(2, 2, 24'h700000, "term11");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
